disp_sched: RTL
===============

# disp_sched

Display scheduler that shares the single 4-digit seven-segment driver between three requesters: alarm, keypad entry and countdown. It arbitrates by fixed priority with a minimum hold time, and routes the winner's 16-bit BCD word and enable to the driver. It can optionally blink the display per requester. It sits between the detonator control logic and the digit-multiplex driver, and drives that driver's `en` and `data` inputs.

## Interface
- `HOLD_CYCLES`, default 1000: minimum cycles a grant is held before a non-alarm switch; must be ≥ 1.
- `BLINK_HALF`, default 25_000_000: cycles per blink half-period. Only used with blink compiled in.
- `clk` in 1: system clock. The block uses this single clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 3: request per source; bit 0 alarm (highest), bit 1 keypad, bit 2 countdown (lowest).
- `data0`, `data1`, `data2` in 16 each: BCD words per source, digit 3 in [15:12].
- `blink` in 3: per-source blink request, sampled while that source is granted.
- `gnt` out 3: one-hot grant, or 0 when idle.
- `disp_en` out 1: display enable to the driver.
- `disp_data` out 16: BCD word to the driver.
- `busy` out 1: high while any source is granted.

## Operation
- FSM states:
  - IDLE: no grant.
  - HOLD: grant held, hold counter > 0.
  - OWN: grant held, hold expired.
- Transitions out of IDLE:
  - Any `req` → HOLD with the highest-priority requester granted.
  - Hold counter loads `HOLD_CYCLES-1`.
- Transitions out of HOLD:
  - Counter decrements each cycle; reaching 0 → OWN.
  - If the owner drops `req`, it keeps the grant; `disp_data` freezes at the owner's last sampled word.
- Transitions out of OWN, evaluated in this order:
  - Higher-priority `req` → HOLD on that source.
  - Owner `req` still high → stay in OWN.
  - Other `req` pending → HOLD on the highest-priority one among them.
  - Otherwise → IDLE.
- Alarm preemption: `req[0]` preempts keypad or countdown from any state, including HOLD. The switch goes to HOLD with the counter reloaded.
- `disp_data` while granted: the owner's data word, registered every cycle the owner's `req` is high.
- Digits > 9 pass through unmodified; the driver renders them as 0.
- In IDLE: `disp_en` = 0, `disp_data` = 16'h0000.
- Hold counter width is `$clog2(HOLD_CYCLES+1)`. It never wraps; it saturates at 0.

## Timing
- All outputs are registered.
- `req` or data sampled at edge N → `gnt`, `busy`, `disp_data` and `disp_en` update at edge N+1.
- Grant switch latency is 1 cycle. There is no cycle with two grant bits set.
- When the owner leaves (switch or IDLE), there is no gap cycle: the new owner's data appears on the same edge as its grant.
- Simultaneous requests: the lowest-index source wins.
- A preempted source's `req` stays pending and is served per the OWN rules later.
- Reset values (asynchronous): state IDLE, `gnt` = 3'b000, `busy` = 0, `disp_en` = 0, `disp_data` = 16'h0000, hold counter 0, blink counter 0, blink phase 1.
- Reset asserted mid-grant clears everything immediately, without waiting for a clock edge. After release, the first edge re-arbitrates from IDLE.

## Configuration
- Macro: `DISP_SCHED_BLINK_EN`.
- Defined:
  - A blink counter toggles a phase bit every `BLINK_HALF` cycles.
  - While granted, `disp_en` = phase if the owner's `blink` bit is 1, otherwise 1.
  - Phase is forced to 1 and the counter is cleared on every grant change, so a new owner is visible immediately.
- Undefined:
  - The `blink` inputs are ignored and the `BLINK_HALF` parameter is unused.
  - `disp_en` = `busy`. No blink counter is instantiated.

## Structure
- Shared package `disp_pkg`:
  - Source index constants: `SRC_ALARM` = 0, `SRC_KEY` = 1, `SRC_CNT` = 2.
  - FSM state encoding: IDLE, HOLD, OWN.
  - Blank word constant: 16'h0000.
- One sub-module, `disp_blink_gen`: the blink counter plus phase bit, with a restart input. It is instantiated only under `DISP_SCHED_BLINK_EN`.
- The arbitration FSM and data mux stay in `disp_sched`.

## Test plan
- **Idle to grant.** Reset, then `req` = 3'b100 with `data2` = 16'h1234 at edge 5.
  - Required: `gnt` = 3'b100, `busy` = 1, `disp_en` = 1, `disp_data` = 16'h1234 at edge 6.
- **Hold, then priority switch.** `HOLD_CYCLES` = 4; countdown granted; keypad raises `req[1]` one cycle later.
  - Required: the grant stays on countdown until the hold expires, then moves to keypad (`gnt` = 3'b010, `disp_data` = `data1`) one cycle after entering OWN.
- **Alarm preemption.** Keypad in HOLD; assert `req[0]` with `data0` = 16'h9999.
  - Required: `gnt` = 3'b001 and `disp_data` = 16'h9999 on the next edge; the hold counter reloads.
- **Owner drop during hold.** `HOLD_CYCLES` = 8; keypad `req` drops after 2 cycles; no other requests.
  - Required: `disp_data` stays frozen until the hold expires, then IDLE with `disp_data` = 0, `gnt` = 0, `busy` = 0.
- **Blink** (with `DISP_SCHED_BLINK_EN`). `BLINK_HALF` = 3; owner with `blink` = 1.
  - Required: `disp_en` pattern 1,1,1,0,0,0,1… from grant.
  - A grant change mid-pattern forces `disp_en` = 1 and restarts the pattern.
  - Without the macro, `disp_en` is steady 1.
- **Asynchronous reset mid-operation.** Assert `rst` between clock edges while granted.
  - Required: all outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants, FSM state encoding and helpers for the display scheduler.
package disp_pkg;

   localparam int unsigned SRC_ALARM = 0;
   localparam int unsigned SRC_KEY   = 1;
   localparam int unsigned SRC_CNT   = 2;

   localparam logic [15:0] BLANK_WORD = 16'h0000;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StOwn
   } state_e;

   // Isolates the lowest set bit, which is the highest-priority requester.
   function automatic logic [2:0] lowest_one(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

endpackage

// File: rtl/disp_blink_gen.sv
// Blink phase generator: toggles phase every BLINK_HALF cycles; restart clears it to phase 1.
module disp_blink_gen #(
   parameter int unsigned BLINK_HALF = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic phase
);

   localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q + CntW'(1);
      phase_d = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == CntLast) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/disp_sched.sv
// Fixed-priority display scheduler with minimum hold time and alarm preemption.
// Optional per-source blinking is compiled in with DISP_SCHED_BLINK_EN.
module disp_sched
   import disp_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned BLINK_HALF  = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   input  logic [2:0]  blink,
   output logic [2:0]  gnt,
   output logic        disp_en,
   output logic [15:0] disp_data,
   output logic        busy
);

   localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

   state_e          state_q, state_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     data_q, data_d;
   logic [2:0]      higher, others;

   function automatic logic [15:0] word_of(input logic [2:0] g, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] c);
      case (g)
         3'b001:  return a;
         3'b010:  return b;
         3'b100:  return c;
         default: return BLANK_WORD;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      // For a one-hot owner, gnt_q - 1 masks exactly the higher-priority sources.
      higher  = req & (gnt_q - 3'd1);
      others  = req & ~gnt_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StHold;
               gnt_d   = lowest_one(req);
               cnt_d   = HoldLoad;
            end
         end
         StHold: begin
            if (req[SRC_ALARM] && !gnt_q[SRC_ALARM]) begin
               gnt_d = 3'b001;
               cnt_d = HoldLoad;
            end else if (cnt_q <= CntW'(1)) begin
               cnt_d   = '0;
               state_d = StOwn;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StOwn: begin
            if (|higher) begin
               state_d = StHold;
               gnt_d   = lowest_one(higher);
               cnt_d   = HoldLoad;
            end else if (|(req & gnt_q)) begin
               state_d = StOwn;
            end else if (|others) begin
               state_d = StHold;
               gnt_d   = lowest_one(others);
               cnt_d   = HoldLoad;
            end else begin
               state_d = StIdle;
               gnt_d   = 3'b000;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 3'b000;
            cnt_d   = '0;
         end
      endcase

      // A new owner's word is taken on its grant edge; otherwise it tracks only while requesting.
      data_d = data_q;
      if (gnt_d == 3'b000) begin
         data_d = BLANK_WORD;
      end else if ((gnt_d != gnt_q) || |(req & gnt_d)) begin
         data_d = word_of(gnt_d, data0, data1, data2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= 3'b000;
         cnt_q   <= '0;
         data_q  <= BLANK_WORD;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = |gnt_q;
   assign disp_data = data_q;

`ifdef DISP_SCHED_BLINK_EN
   logic phase;
   logic blink_q, blink_d;

   disp_blink_gen #(
      .BLINK_HALF(BLINK_HALF)
   ) u_blink (
      .clk    (clk),
      .rst    (rst),
      .restart(gnt_d != gnt_q),
      .phase  (phase)
   );

   always_comb blink_d = |(blink & gnt_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) blink_q <= 1'b0;
      else     blink_q <= blink_d;
   end

   assign disp_en = busy & (~blink_q | phase);
`else
   logic unused_blink;
   localparam int unsigned unused_blink_half = BLINK_HALF;
   assign unused_blink = ^blink;
   assign disp_en      = busy;
`endif

endmodule
